// File: rtl/mont_mul_if.sv
// Operand/result bundle for the bit-serial Montgomery multiplier.
// Latency: none; this file only carries signals.
// Backpressure: none; in_sig is a start strobe that is honoured only while the multiplier is idle.
// Signals: in_sig/A_i/B_i/Prime flow master->slave; Z_out/done/busy flow slave->master.
interface mont_mul_if #(
  parameter int WIDTH = 32
);
  logic             in_sig;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic [WIDTH-1:0] Prime;
  logic [WIDTH-1:0] Z_out;
  logic             done;
  logic             busy;

  modport master (
    output in_sig, A_i, B_i, Prime,
    input  Z_out, done, busy
  );

  modport slave (
    input  in_sig, A_i, B_i, Prime,
    output Z_out, done, busy
  );
endinterface

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: Z = A*B*2^-WIDTH mod Prime.
// Latency: done rises WIDTH+2 edges after the accept edge (accept edge counted as the first).
// Backpressure: none; in_sig is ignored outside IDLE, so the minimum issue interval is WIDTH+3 cycles.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries in_sig, A_i, B_i, Prime in and
//        Z_out, done, busy out.
// Build option: define MONT_MUL_IN_REDUCE_EN to fold operands in [Prime, 2*Prime) down at accept.
module mont_mul #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mont_mul_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_REDUCE,
    S_OUT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [WIDTH+1:0] s_q;          // two guard bits: S + B + P < 4P fits
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] z_q;
  logic             done_q, busy_q;

  logic [WIDTH+1:0] t_add, s_d, s_red;
  logic [WIDTH-1:0] a_d, b_d;

  always_comb begin
    // One Montgomery step: add B if the current A bit is set, then add P
    // to make the sum even so the halving is exact modulo P.
    t_add = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    s_d   = t_add[0] ? (t_add + {2'b00, p_q}) >> 1 : t_add >> 1;
    // S < 2P after the last step, so one conditional subtraction finishes.
    s_red = (s_q >= {2'b00, p_q}) ? s_q - {2'b00, p_q} : s_q;
  end

  always_comb begin
`ifdef MONT_MUL_IN_REDUCE_EN
    a_d = (bus.A_i >= bus.Prime) ? bus.A_i - bus.Prime : bus.A_i;
    b_d = (bus.B_i >= bus.Prime) ? bus.B_i - bus.Prime : bus.B_i;
`else
    a_d = bus.A_i;
    b_d = bus.B_i;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_sig) begin
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= bus.Prime;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          s_q <= s_d;
          a_q <= a_q >> 1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_REDUCE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REDUCE: begin
          z_q     <= s_red[WIDTH-1:0];
          done_q  <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          // A start strobe here is dropped; the next accept needs IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Z_out = z_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mont_mul.sv
// Directed-vector bench for mont_mul with a queue scoreboard and an independent done monitor.
// Latency: checks done arrives WIDTH+1 edges after the accept edge and lasts one cycle.
// Backpressure: checks that starts outside IDLE are dropped and the issue interval is WIDTH+3.
module tb_mont_mul;
  localparam int W   = 32;
  localparam int LAT = W + 1;   // edges from the accept edge to the edge that raises done

  typedef struct {
    logic [W-1:0] z;
    bit           chk_z;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mont_mul_if #(.WIDTH(W)) bus ();
  mont_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   done_cycs[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   prev_done = 1'b0;
  exp_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_done) begin
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);
        check("busy_after_out", {63'd0, bus.busy}, 64'd0);
      end
      prev_done = (bus.done === 1'b1);
      if (bus.done === 1'b1) begin
        done_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
        end else begin
          m_e = sb.pop_front();
          check("latency", 64'(cyc - m_e.acc), 64'(LAT));
          if (m_e.chk_z) check("z_out", {32'd0, bus.Z_out}, {32'd0, m_e.z});
        end
      end
    end
  end

  // Called at a negedge; the start is accepted at the next posedge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p,
                       input logic [W-1:0] z, input bit chk);
    bus.A_i    = a;
    bus.B_i    = b;
    bus.Prime  = p;
    bus.in_sig = 1'b1;
    sb.push_back(exp_t'{z: z, chk_z: chk, acc: cyc + 1});
    @(negedge clk);
    bus.in_sig = 1'b0;
    check("busy_on_accept", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("wait_idle");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("scoreboard_drain");
  endtask

  initial begin
    reset      = 1'b1;
    bus.in_sig = 1'b0;
    bus.A_i    = '0;
    bus.B_i    = '0;
    bus.Prime  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_z", {32'd0, bus.Z_out}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);

    // R mod 23 = 12, R^-1 mod 23 = 2: Z = 2*A*B mod 23.
    start(32'd12, 32'd12, 32'd23, 32'd12, 1'b1);
    wait_idle();
    wait_drain();

    // Back-to-back: second start lands in the first IDLE cycle.
    start(32'd12, 32'd5, 32'd23, 32'd5, 1'b1);
    wait_idle();
    start(32'd0, 32'd17, 32'd23, 32'd0, 1'b1);
    wait_idle();
    wait_drain();
    if (done_cycs.size() >= 2)
      check("issue_interval", 64'(done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2]), 64'(W + 3));
    else
      fail_now("issue_interval");

    // Near-max modulus, R mod P = 5, so A = 5 is Montgomery one: Z = B.
    start(32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b1);
    wait_idle();

    // Start strobe mid-operation must be dropped.
    start(32'd12, 32'd5, 32'd23, 32'd5, 1'b1);
    repeat (9) @(negedge clk);
    bus.A_i    = 32'd1;
    bus.in_sig = 1'b1;
    @(negedge clk);
    bus.in_sig = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_restart", {63'd0, bus.busy}, 64'd0);
    wait_drain();

    // Reset mid-operation discards everything.
    start(32'd12, 32'd12, 32'd23, 32'd12, 1'b1);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    check("abort_z", {32'd0, bus.Z_out}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    start(32'd12, 32'd12, 32'd23, 32'd12, 1'b1);
    wait_idle();

    // More patterns: 2*1*1=2, 2*22*22 mod 23=2, 2*3*4 mod 23=1; mod 7 R^-1=2: 2*5*3 mod 7=2.
    start(32'd1, 32'd1, 32'd23, 32'd2, 1'b1);
    wait_idle();
    start(32'd22, 32'd22, 32'd23, 32'd2, 1'b1);
    wait_idle();
    start(32'd3, 32'd4, 32'd23, 32'd1, 1'b1);
    wait_idle();
    start(32'd5, 32'd3, 32'd7, 32'd2, 1'b1);
    wait_idle();

    // Out-of-range A: folded to 12 when input reduction is built in, else only timing is checked.
`ifdef MONT_MUL_IN_REDUCE_EN
    start(32'd35, 32'd7, 32'd23, 32'd7, 1'b1);
`else
    start(32'd35, 32'd7, 32'd23, 32'd0, 1'b0);
`endif
    wait_idle();
    wait_drain();
    repeat (2) @(negedge clk);
    check("z_held", {32'd0, bus.Z_out} == 64'd0 ? 64'd0 : 64'd1, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
